// File: rtl/vc_input_unit.sv
// rtl/vc_input_unit.sv - virtual-channel router input unit with per-VC FIFOs, dimension-order routing and round-robin output
// Optional feature macro: ROUTE_CHECK_EN (head CHECK bit vs. even parity of DST; bad packets are dropped)
module vc_input_unit #(
   parameter logic [2:0] X         = 3'd0,
   parameter logic [2:0] Y         = 3'd0,
   parameter logic [2:0] Z         = 3'd0,
   parameter int          FLIT_SIZE = 64,
   parameter int          NUM_VC    = 2,
   parameter int          VC_DEPTH  = 8,
   localparam int         VCW       = $clog2(NUM_VC)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLIT_SIZE-1:0] data_in,
   input  logic                 valid_in,
   input  logic [VCW-1:0]       vc_in,
   output logic                 credit_out,
   output logic [VCW-1:0]       credit_vc,
   output logic                 out_req,
   output logic [2:0]           out_port,
   output logic [VCW-1:0]       out_vc,
   output logic [FLIT_SIZE-1:0] out_data,
   input  logic                 out_grant,
   output logic                 overflow,
   output logic [7:0]           drop_cnt
);
   localparam int AW = $clog2(VC_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_ACTIVE, S_DROP} vc_state_t;

   logic [FLIT_SIZE-1:0] mem [NUM_VC][VC_DEPTH];
   logic [AW:0]          wr_ptr [NUM_VC];
   logic [AW:0]          rd_ptr [NUM_VC];
   logic [FLIT_SIZE-1:0] front [NUM_VC];
   logic [1:0]           ftype [NUM_VC];
   logic [2:0]           route [NUM_VC];
   vc_state_t            state [NUM_VC];
   vc_state_t            state_nxt [NUM_VC];
   logic [NUM_VC-1:0]    empty, full, elig, deq, wr_ok, bad_check;
   logic [VCW-1:0]       rr_ptr, sel, lock_vc, idx;
   logic                 locked, found, granted, maint_taken;
   logic [7:0]           drop_nxt;

   // head and single share equal type bits; tail and single have bit 1 set
   function automatic logic is_head(input logic [1:0] t);
      return t[1] == t[0];
   endfunction

   function automatic logic is_last(input logic [1:0] t);
      return t[1];
   endfunction

   // dimension-order routing on the {x,y,z} destination field
   function automatic logic [2:0] calc_route(input logic [8:0] dst);
      logic [2:0] dx, dy, dz;
      dx = dst[8:6];
      dy = dst[5:3];
      dz = dst[2:0];
      if (dx > X)      return 3'd1;
      else if (dx < X) return 3'd2;
      else if (dy > Y) return 3'd3;
      else if (dy < Y) return 3'd4;
      else if (dz > Z) return 3'd5;
      else if (dz < Z) return 3'd6;
      else             return 3'd0;
   endfunction

   // per-VC FIFO status, front flit and write acceptance
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         empty[v] = (wr_ptr[v] == rd_ptr[v]);
         full[v]  = (wr_ptr[v][AW] != rd_ptr[v][AW]) && (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
         front[v] = mem[v][rd_ptr[v][AW-1:0]];
         ftype[v] = front[v][FLIT_SIZE-1 -: 2];
         elig[v]  = (state[v] == S_ACTIVE) && !empty[v];
         wr_ok[v] = valid_in && (vc_in == VCW'(v)) && (!full[v] || deq[v]);
`ifdef ROUTE_CHECK_EN
         bad_check[v] = front[v][FLIT_SIZE-12] != (^front[v][FLIT_SIZE-3 -: 9]);
`else
         bad_check[v] = 1'b0;
`endif
      end
   end

   // round-robin selection, locked onto the offered VC until it is granted
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      if (locked) begin
         found = 1'b1;
         sel   = lock_vc;
      end else begin
         for (int i = 0; i < NUM_VC; i++) begin
            idx = rr_ptr + VCW'(i);
            if (!found && elig[idx]) begin
               found = 1'b1;
               sel   = idx;
            end
         end
      end
   end

   // output process: one dequeue per cycle, switch grant first, drop/discard only when nothing is offered
   always_comb begin
      out_req     = found && !rst;
      granted     = out_req && out_grant;
      deq         = '0;
      maint_taken = 1'b0;
      if (granted) begin
         deq[sel] = 1'b1;
      end else if (!out_req && !rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (!maint_taken && !empty[v] &&
                (state[v] == S_DROP || (state[v] == S_IDLE && !is_head(ftype[v])))) begin
               deq[v]      = 1'b1;
               maint_taken = 1'b1;
            end
         end
      end
      credit_out = |deq;
      credit_vc  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (deq[v]) credit_vc = VCW'(v);
      end
      out_port = out_req ? route[sel] : 3'd0;
      out_vc   = out_req ? sel : '0;
      out_data = out_req ? front[sel] : '0;
   end

   // next-state process; IDLE looks at the incoming flit when its FIFO is empty to save a cycle
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         state_nxt[v] = state[v];
         case (state[v])
            S_IDLE: begin
               if (!empty[v]) begin
                  if (is_head(ftype[v])) state_nxt[v] = S_ROUTE;
               end else if (valid_in && vc_in == VCW'(v) && is_head(data_in[FLIT_SIZE-1 -: 2])) begin
                  state_nxt[v] = S_ROUTE;
               end
            end
            S_ROUTE:  state_nxt[v] = bad_check[v] ? S_DROP : S_ACTIVE;
            S_ACTIVE,
            S_DROP: begin
               if (deq[v] && is_last(ftype[v])) state_nxt[v] = S_IDLE;
            end
            default:  state_nxt[v] = S_IDLE;
         endcase
      end
   end

   // saturating count of packets rejected in ROUTE
   always_comb begin
      drop_nxt = drop_cnt;
      for (int v = 0; v < NUM_VC; v++) begin
         if (state[v] == S_ROUTE && bad_check[v] && drop_nxt != 8'hFF) drop_nxt = drop_nxt + 8'd1;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (rst) state[v] <= S_IDLE;
         else     state[v] <= state_nxt[v];
      end
   end

   // FIFO storage, no reset needed since pointers define validity
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (wr_ok[v]) mem[v][wr_ptr[v][AW-1:0]] <= data_in;
      end
   end

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
         end
         overflow <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (deq[v])   rd_ptr[v] <= rd_ptr[v] + 1'b1;
            if (wr_ok[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
            if (valid_in && vc_in == VCW'(v) && !wr_ok[v]) overflow <= 1'b1;
            if (deq[v] && state[v] == S_IDLE) overflow <= 1'b1;
         end
      end
   end

   // route registers, arbitration pointer, offer lock and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VC; v++) route[v] <= 3'd0;
         rr_ptr   <= '0;
         locked   <= 1'b0;
         lock_vc  <= '0;
         drop_cnt <= 8'd0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (state[v] == S_ROUTE) route[v] <= calc_route(front[v][FLIT_SIZE-3 -: 9]);
         end
         locked   <= out_req && !out_grant;
         lock_vc  <= sel;
         drop_cnt <= drop_nxt;
         if (granted) rr_ptr <= sel + 1'b1;
      end
   end
endmodule

// File: tb/tb_vc_input_unit.sv
// tb/tb_vc_input_unit.sv - directed self-checking bench for vc_input_unit
module tb_vc_input_unit;
   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic        valid_in;
   logic [0:0]  vc_in;
   logic        credit_out;
   logic [0:0]  credit_vc;
   logic        out_req;
   logic [2:0]  out_port;
   logic [0:0]  out_vc;
   logic [15:0] out_data;
   logic        out_grant;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   vc_input_unit #(
      .X(3'd2), .Y(3'd2), .Z(3'd2),
      .FLIT_SIZE(16), .NUM_VC(2), .VC_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .vc_in(vc_in),
      .credit_out(credit_out), .credit_vc(credit_vc), .out_req(out_req), .out_port(out_port),
      .out_vc(out_vc), .out_data(out_data), .out_grant(out_grant),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 16-bit flit: type[15:14] dst{x,y,z}[13:5] check[4] payload[3:0]
   function automatic logic [15:0] mk(input logic [1:0] t, input logic [2:0] x, input logic [2:0] y,
                                      input logic [2:0] z, input logic [3:0] p, input logic bad);
      logic [8:0] d;
      d = {x, y, z};
      return {t, d, (^d) ^ bad, p};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; valid_in = 1'b0; out_grant = 1'b0; data_in = '0; vc_in = '0;
      step; step;
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL reset_out_req: got %0d want 0", out_req); end
      checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit_out); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0d want 0", overflow); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_single;
      logic [15:0] f;
      f = mk(2'b11, 3'd5, 3'd2, 3'd2, 4'hA, 1'b0);
      out_grant = 1'b0; data_in = f; vc_in = 1'b0; valid_in = 1'b1;
      #1;
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL single_t0_req: got %0d want 0", out_req); end
      step; valid_in = 1'b0;
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL single_t1_req: got %0d want 0", out_req); end
      step;
      checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL single_t2_req: got %0d want 1", out_req); end
      checks++; if (out_port !== 3'd1) begin errors++; $display("FAIL single_port: got %0d want 1", out_port); end
      checks++; if (out_vc !== 1'b0) begin errors++; $display("FAIL single_vc: got %0d want 0", out_vc); end
      checks++; if (out_data !== f) begin errors++; $display("FAIL single_data: got %h want %h", out_data, f); end
      out_grant = 1'b1; #1;
      checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL single_credit: got %0d want 1", credit_out); end
      checks++; if (credit_vc !== 1'b0) begin errors++; $display("FAIL single_credit_vc: got %0d want 0", credit_vc); end
      step; out_grant = 1'b0;
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL single_after_req: got %0d want 0", out_req); end
   endtask

   task automatic test_packet;
      logic [15:0] pk [4];
      pk[0] = mk(2'b00, 3'd2, 3'd2, 3'd2, 4'h1, 1'b0);
      pk[1] = mk(2'b01, 3'd2, 3'd2, 3'd2, 4'h2, 1'b0);
      pk[2] = mk(2'b01, 3'd2, 3'd2, 3'd2, 4'h3, 1'b0);
      pk[3] = mk(2'b10, 3'd2, 3'd2, 3'd2, 4'h4, 1'b0);
      out_grant = 1'b1; vc_in = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c < 4) begin data_in = pk[c]; valid_in = 1'b1; end
         else valid_in = 1'b0;
         #1;
         if (c >= 2 && c < 6) begin
            checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL packet_req c%0d: got %0d want 1", c, out_req); end
            checks++; if (out_data !== pk[c-2]) begin errors++; $display("FAIL packet_data c%0d: got %h want %h", c, out_data, pk[c-2]); end
            checks++; if (out_port !== 3'd0) begin errors++; $display("FAIL packet_port c%0d: got %0d want 0", c, out_port); end
            checks++; if (credit_out !== 1'b1 || credit_vc !== 1'b1) begin errors++; $display("FAIL packet_credit c%0d: got %0d/%0d want 1/1", c, credit_out, credit_vc); end
         end else begin
            checks++; if (out_req !== 1'b0 || credit_out !== 1'b0) begin errors++; $display("FAIL packet_idle c%0d: got req %0d credit %0d want 0/0", c, out_req, credit_out); end
         end
         step;
      end
      out_grant = 1'b0;
   endtask

   task automatic test_interleave;
      logic [15:0] sq [4];
      logic [0:0]  sv [4];
      logic [0:0]  ev;
      logic [2:0]  ep;
      sq[0] = mk(2'b00, 3'd2, 3'd5, 3'd2, 4'h5, 1'b0); sv[0] = 1'b0;
      sq[1] = mk(2'b00, 3'd2, 3'd2, 3'd0, 4'h6, 1'b0); sv[1] = 1'b1;
      sq[2] = mk(2'b10, 3'd2, 3'd5, 3'd2, 4'h7, 1'b0); sv[2] = 1'b0;
      sq[3] = mk(2'b10, 3'd2, 3'd2, 3'd0, 4'h8, 1'b0); sv[3] = 1'b1;
      out_grant = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c < 4) begin data_in = sq[c]; vc_in = sv[c]; valid_in = 1'b1; end
         else valid_in = 1'b0;
         #1;
         if (c >= 2 && c < 6) begin
            ev = sv[c-2];
            ep = ev ? 3'd6 : 3'd3;
            checks++; if (out_req !== 1'b1 || out_vc !== ev) begin errors++; $display("FAIL inter_vc c%0d: got req %0d vc %0d want 1/%0d", c, out_req, out_vc, ev); end
            checks++; if (out_port !== ep) begin errors++; $display("FAIL inter_port c%0d: got %0d want %0d", c, out_port, ep); end
            checks++; if (out_data !== sq[c-2]) begin errors++; $display("FAIL inter_data c%0d: got %h want %h", c, out_data, sq[c-2]); end
         end
         step;
      end
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL inter_end_req: got %0d want 0", out_req); end
      out_grant = 1'b0;
   endtask

   task automatic test_overflow;
      logic [15:0] ov [6];
      logic [15:0] t;
      ov[0] = mk(2'b00, 3'd2, 3'd2, 3'd2, 4'h0, 1'b0);
      for (int i = 1; i < 6; i++) ov[i] = mk(2'b01, 3'd2, 3'd2, 3'd2, 4'(i), 1'b0);
      t = mk(2'b10, 3'd2, 3'd2, 3'd2, 4'hF, 1'b0);
      out_grant = 1'b0; vc_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         data_in = ov[c]; valid_in = 1'b1; step;
      end
      // FIFO full: write together with a grant must be accepted
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_flag: got %0d want 0", overflow); end
      checks++; if (out_req !== 1'b1 || out_data !== ov[0]) begin errors++; $display("FAIL ovf_hold: got req %0d data %h want 1/%h", out_req, out_data, ov[0]); end
      data_in = ov[4]; out_grant = 1'b1; #1;
      checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL ovf_simul_credit: got %0d want 1", credit_out); end
      step;
      out_grant = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_simul_flag: got %0d want 0", overflow); end
      checks++; if (out_data !== ov[1]) begin errors++; $display("FAIL ovf_front: got %h want %h", out_data, ov[1]); end
      data_in = ov[5]; step;
      valid_in = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0d want 1", overflow); end
      out_grant = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (out_req !== 1'b1 || out_data !== ov[1+k]) begin errors++; $display("FAIL ovf_drain k%0d: got req %0d data %h want 1/%h", k, out_req, out_data, ov[1+k]); end
         step;
      end
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL ovf_discarded: got req %0d want 0", out_req); end
      data_in = t; valid_in = 1'b1; step;
      valid_in = 1'b0;
      checks++; if (out_req !== 1'b1 || out_data !== t) begin errors++; $display("FAIL ovf_tail: got req %0d data %h want 1/%h", out_req, out_data, t); end
      step;
      out_grant = 1'b0;
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL ovf_tail_done: got %0d want 0", out_req); end
   endtask

   task automatic test_mid_reset;
      logic [15:0] f;
      out_grant = 1'b0; vc_in = 1'b0;
      data_in = mk(2'b00, 3'd5, 3'd2, 3'd2, 4'h1, 1'b0); valid_in = 1'b1; step;
      data_in = mk(2'b01, 3'd5, 3'd2, 3'd2, 4'h2, 1'b0); step;
      valid_in = 1'b0;
      checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL mrst_pre_req: got %0d want 1", out_req); end
      rst = 1'b1; out_grant = 1'b1; #1;
      checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL mrst_no_credit: got %0d want 0", credit_out); end
      step;
      rst = 1'b0; out_grant = 1'b0; #1;
      checks++; if (out_req !== 1'b0 || credit_out !== 1'b0 || credit_vc !== 1'b0) begin errors++; $display("FAIL mrst_req_credit: got %0d/%0d/%0d want 0/0/0", out_req, credit_out, credit_vc); end
      checks++; if (out_port !== 3'd0 || out_vc !== 1'b0 || out_data !== 16'h0) begin errors++; $display("FAIL mrst_outs: got %0d/%0d/%h want 0/0/0", out_port, out_vc, out_data); end
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL mrst_flags: got %0d/%0d want 0/0", overflow, drop_cnt); end
      f = mk(2'b11, 3'd2, 3'd2, 3'd5, 4'h9, 1'b0);
      data_in = f; vc_in = 1'b1; valid_in = 1'b1; step;
      valid_in = 1'b0; step;
      checks++; if (out_req !== 1'b1 || out_port !== 3'd5 || out_vc !== 1'b1) begin errors++; $display("FAIL mrst_new: got req %0d port %0d vc %0d want 1/5/1", out_req, out_port, out_vc); end
      checks++; if (out_data !== f) begin errors++; $display("FAIL mrst_new_data: got %h want %h", out_data, f); end
      out_grant = 1'b1; step;
      out_grant = 1'b0;
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL mrst_old_gone: got %0d want 0", out_req); end
   endtask

   task automatic test_idle_body;
      data_in = mk(2'b01, 3'd1, 3'd1, 3'd1, 4'h3, 1'b0); vc_in = 1'b1; valid_in = 1'b1; step;
      valid_in = 1'b0; #1;
      checks++; if (credit_out !== 1'b1 || credit_vc !== 1'b1) begin errors++; $display("FAIL orphan_credit: got %0d/%0d want 1/1", credit_out, credit_vc); end
      checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL orphan_req: got %0d want 0", out_req); end
      step;
      checks++; if (overflow !== 1'b1 || credit_out !== 1'b0) begin errors++; $display("FAIL orphan_flag: got ovf %0d credit %0d want 1/0", overflow, credit_out); end
   endtask

   task automatic test_drop;
      logic [15:0] dp [3];
      int reqs, credits;
      dp[0] = mk(2'b00, 3'd5, 3'd2, 3'd2, 4'h1, 1'b1);
      dp[1] = mk(2'b01, 3'd5, 3'd2, 3'd2, 4'h2, 1'b0);
      dp[2] = mk(2'b10, 3'd5, 3'd2, 3'd2, 4'h3, 1'b0);
      reqs = 0; credits = 0;
      out_grant = 1'b1; vc_in = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c < 3) begin data_in = dp[c]; valid_in = 1'b1; end
         else valid_in = 1'b0;
         #1;
         if (out_req === 1'b1) reqs++;
         if (credit_out === 1'b1) credits++;
         step;
      end
      out_grant = 1'b0;
      checks++; if (credits !== 3) begin errors++; $display("FAIL drop_credits: got %0d want 3", credits); end
`ifdef ROUTE_CHECK_EN
      checks++; if (reqs !== 0) begin errors++; $display("FAIL drop_reqs: got %0d want 0", reqs); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
`else
      checks++; if (reqs !== 3) begin errors++; $display("FAIL nodrop_reqs: got %0d want 3", reqs); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL nodrop_cnt: got %0d want 0", drop_cnt); end
`endif
   endtask

   initial begin
      test_reset;
      test_single;
      test_packet;
      test_interleave;
      test_overflow;
      test_mid_reset;
      test_idle_body;
      test_drop;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
